// File: rtl/des_pkg.sv
// Shared types and helpers for the DES key-search scheduler.
package des_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Spread a 56-bit key into DES layout: 7 key bits per byte in [7:1], parity bit 0 left zero.
  function automatic logic [63:0] expand(input logic [55:0] k);
    logic [63:0] r;
    r = '0;
    for (int g = 0; g < 8; g++) r[8*g+1 +: 7] = k[7*g +: 7];
    return r;
  endfunction

endpackage

// File: rtl/des_pick.sv
// Lowest-set-bit one-hot picker with an any-set flag.
module des_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  always_comb begin
    gnt = '0;
    for (int i = N-1; i >= 0; i--)
      if (req[i]) gnt = N'(1) << i;
  end

  assign any = |req;

endmodule

// File: rtl/des_sched.sv
// Chunk dispatcher for a bank of DES key-search cores: hands out key ranges,
// latches the first hit, aborts the bank and waits for it to drain.
module des_sched
  import des_pkg::*;
#(
  parameter int N         = 4,
  parameter int CHUNK_LOG = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            stop,
  input  logic [55:0]     key_first,
  input  logic [55:0]     key_last,
  output logic [N-1:0]    core_run,
  output logic [63:0]     core_key,
  output logic            core_abort,
  input  logic [N-1:0]    core_busy,
  input  logic [N-1:0]    core_found,
  input  logic [64*N-1:0] core_res,
  output logic            busy,
  output logic            done,
  output logic            found,
  output logic [63:0]     found_key,
  output logic [31:0]     chunks
);

  localparam logic [56:0] STEP = 57'd1 << CHUNK_LOG;

  state_t      state;
  logic [56:0] next_key;
  logic [N-1:0] pending, free, pick;
  logic        any_free, exhausted, hit;
  logic [63:0] hit_res;

  // A core stays reserved from its run pulse until it reports busy.
  assign free = ~core_busy & ~pending;

  des_pick #(.N(N)) u_pick (.req(free), .gnt(pick), .any(any_free));

  always_comb begin
    hit_res = '0;
    for (int i = N-1; i >= 0; i--)
      if (core_found[i]) hit_res = core_res[64*i +: 64];
  end

  // Bit 56 catches the base wrapping past the top of the 56-bit key space.
  assign exhausted = next_key[56] || (next_key[55:0] > key_last);
  assign hit       = (|core_found) && !found;
  assign busy      = (state == S_DISPATCH) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      next_key   <= '0;
      pending    <= '0;
      core_run   <= '0;
      core_key   <= '0;
      core_abort <= 1'b0;
      found      <= 1'b0;
      found_key  <= '0;
      chunks     <= '0;
    end else begin
      core_run   <= '0;
      core_abort <= 1'b0;
      pending    <= pending & ~core_busy;
      case (state)
        S_IDLE, S_DONE: begin
          if (go) begin
            next_key <= {1'b0, key_first};
            found    <= 1'b0;
            chunks   <= '0;
            pending  <= '0;
            state    <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (hit) begin
            found      <= 1'b1;
            found_key  <= hit_res;
            core_abort <= 1'b1;
            state      <= S_DRAIN;
          end else if (stop) begin
            core_abort <= 1'b1;
            state      <= S_DRAIN;
          end else if (exhausted) begin
            state <= S_DRAIN;
          end else if (any_free) begin
            core_run <= pick;
            core_key <= expand(next_key[55:0]);
            next_key <= next_key + STEP;
            pending  <= (pending & ~core_busy) | pick;
            if (chunks != '1) chunks <= chunks + 32'd1;
          end
        end
        S_DRAIN: begin
          if (hit) begin
            found      <= 1'b1;
            found_key  <= hit_res;
            core_abort <= 1'b1;
          end else if (core_busy == '0 && pending == '0) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sched.sv
// Randomized bench for des_sched: a chunk-queue reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_des_sched;
  localparam int NC = 2;
  localparam int CL = 4;

  logic clk = 0, rst = 1, go = 0, stop = 0;
  logic [55:0] key_first = '0, key_last = '0;
  logic [NC-1:0] core_busy = '0, core_found = '0;
  logic [64*NC-1:0] core_res = '0;
  logic [NC-1:0] core_run;
  logic [63:0] core_key, found_key;
  logic core_abort, busy, done, found;
  logic [31:0] chunks;

  des_sched #(.N(NC), .CHUNK_LOG(CL)) dut (
    .clk(clk), .rst(rst), .go(go), .stop(stop), .key_first(key_first), .key_last(key_last),
    .core_run(core_run), .core_key(core_key), .core_abort(core_abort), .core_busy(core_busy),
    .core_found(core_found), .core_res(core_res), .busy(busy), .done(done), .found(found),
    .found_key(found_key), .chunks(chunks));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mph_t;
  mph_t m_ph = M_IDLE;
  longint unsigned q_bases[$];
  logic [NC-1:0] m_pend = '0, m_run = '0;
  logic m_abort = 0, m_fnd = 0;
  logic [63:0] m_fkey = '0, m_key = '0;
  int m_cnt = 0;

  int rem[NC];
  bit harm[NC];
  logic [63:0] hit_val[NC];
  int hit_chunk = -1, lat_lo = 3, lat_hi = 3;
  bit dual_arm = 0, spur_en = 0;

  logic [63:0] keys_seen[$];
  int n_abort = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] bexpand(input logic [55:0] k);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < 56; b++) r[(b/7)*8 + (b%7) + 1] = k[b];
    return r;
  endfunction

  task automatic latch_hit();
    bit got;
    got = 0;
    for (int i = 0; i < NC; i++)
      if (core_found[i] && !got) begin m_fkey = core_res[64*i +: 64]; got = 1; end
    m_fnd = 1; m_abort = 1; m_ph = M_DRAIN;
  endtask

  // Reference: the search is a queue of chunk bases; each edge pops at most one.
  task automatic model_edge();
    logic [NC-1:0] fr;
    longint unsigned b;
    bit clr;
    m_run = '0; m_abort = 0; clr = 0;
    if (rst) begin
      m_ph = M_IDLE; m_pend = '0; m_fnd = 0; m_fkey = '0; m_key = '0; m_cnt = 0;
      q_bases.delete();
      return;
    end
    case (m_ph)
      M_IDLE, M_DONE: if (go) begin
        q_bases.delete();
        b = 64'(key_first);
        while (b <= 64'(key_last) && b < 64'h0100_0000_0000_0000) begin
          q_bases.push_back(b);
          b += 64'd1 << CL;
        end
        m_fnd = 0; m_cnt = 0; clr = 1; m_ph = M_RUN;
      end
      M_RUN: begin
        if (core_found != '0 && !m_fnd) latch_hit();
        else if (stop) begin m_abort = 1; m_ph = M_DRAIN; end
        else if (q_bases.size() == 0) m_ph = M_DRAIN;
        else begin
          fr = ~core_busy & ~m_pend;
          for (int i = 0; i < NC; i++) if (fr[i] && m_run == '0) m_run[i] = 1'b1;
          if (m_run != '0) begin
            b = q_bases.pop_front();
            m_key = bexpand(b[55:0]);
            m_cnt++;
          end
        end
      end
      M_DRAIN: begin
        if (core_found != '0 && !m_fnd) latch_hit();
        else if (core_busy == '0 && m_pend == '0) m_ph = M_DONE;
      end
      default: ;
    endcase
    m_pend = clr ? '0 : ((m_pend & ~core_busy) | m_run);
  endtask

  task automatic compare();
    chk("core_run", 64'(core_run), 64'(m_run));
    chk("core_abort", 64'(core_abort), 64'(m_abort));
    chk("core_key", core_key, m_key);
    chk("busy", 64'(busy), 64'(m_ph == M_RUN || m_ph == M_DRAIN));
    chk("done", 64'(done), 64'(m_ph == M_DONE));
    chk("found", 64'(found), 64'(m_fnd));
    chk("found_key", found_key, m_fkey);
    chk("chunks", 64'(chunks), 64'(m_cnt));
    if (core_run != '0) keys_seen.push_back(core_key);
    if (core_abort) n_abort++;
  endtask

  task automatic cores_update();
    core_found = '0;
    for (int i = 0; i < NC; i++) begin
      if (m_run[i]) begin
        core_busy[i] = 1'b1;
        rem[i] = $urandom_range(lat_lo, lat_hi);
        harm[i] = (m_cnt == hit_chunk);
      end else if (core_busy[i]) begin
        if (m_abort) begin harm[i] = 0; if (rem[i] > 1) rem[i] = 1; end
        rem[i]--;
        if (harm[i]) begin
          core_found[i] = 1'b1;
          core_res[64*i +: 64] = hit_val[i];
          harm[i] = 0;
        end
        if (rem[i] <= 0) core_busy[i] = 1'b0;
      end
    end
    if (dual_arm && core_busy == '1) begin
      core_found = '1;
      for (int i = 0; i < NC; i++) core_res[64*i +: 64] = hit_val[i];
      dual_arm = 0;
    end
    if (spur_en && (m_ph == M_IDLE || m_ph == M_DONE) && $urandom_range(0, 3) == 0) begin
      int c;
      c = $urandom_range(0, NC-1);
      core_found[c] = 1'b1;
      core_res[64*c +: 64] = {$urandom, $urandom};
    end
  endtask

  task automatic step(input bit g = 0, input bit s = 0, input bit r = 0);
    @(negedge clk);
    model_edge();
    compare();
    cores_update();
    go = g; stop = s; rst = r;
  endtask

  task automatic setup(input int lo, input int hi, input int hc, input bit dual, input bit spur);
    lat_lo = lo; lat_hi = hi; hit_chunk = hc; dual_arm = dual; spur_en = spur;
    for (int i = 0; i < NC; i++) harm[i] = 0;
  endtask

  task automatic run_search(input logic [55:0] f, input logic [55:0] l,
                            input bit drain_go, input bit noise);
    bit gd;
    gd = 0;
    keys_seen.delete(); n_abort = 0;
    key_first = f; key_last = l;
    step(1);
    step();
    for (int cyc = 0; cyc < 3000 && m_ph != M_DONE; cyc++) begin
      bit g, s;
      g = 0; s = 0;
      if (drain_go && !gd && m_ph == M_DRAIN) begin g = 1; gd = 1; end
      if (noise) begin
        if ($urandom_range(0, 9) == 0) g = 1;
        if (m_ph == M_RUN && $urandom_range(0, 30) == 0) s = 1;
      end
      step(g, s);
    end
    chk("search_reaches_done", 64'(done), 64'd1);
  endtask

  initial begin
    logic [63:0] exp_keys [4];
    exp_keys = '{64'h0, 64'h20, 64'h40, 64'h60};
    hit_val[0] = 64'h1111_2222_3333_4444;
    hit_val[1] = 64'h0123_4567_89AB_CDEF;

    step(0, 0, 1); step(0, 0, 1); step();
    chk("reset_chunks", 64'(chunks), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);

    // Plain sweep of 64 keys in 16-key chunks.
    setup(3, 3, -1, 0, 0);
    run_search(56'd0, 56'd63, 0, 0);
    chk("sweep_chunks", 64'(chunks), 64'd4);
    chk("sweep_nkeys", 64'(keys_seen.size()), 64'd4);
    for (int k = 0; k < 4; k++) chk("sweep_key", keys_seen[k], exp_keys[k]);
    chk("sweep_found", 64'(found), 64'd0);

    // Core 1 hits while searching chunk 2.
    setup(3, 3, 2, 0, 0);
    run_search(56'd0, 56'd63, 0, 0);
    chk("hit_found", 64'(found), 64'd1);
    chk("hit_key", found_key, 64'h0123_4567_89AB_CDEF);
    chk("hit_abort_pulses", 64'(n_abort), 64'd1);
    chk("hit_chunks", 64'(chunks), 64'd2);

    // Both cores hit together: lower index wins.
    hit_val[1] = 64'h5555_6666_7777_8888;
    setup(4, 4, -1, 1, 0);
    run_search(56'd0, 56'd63, 0, 0);
    chk("dual_key", found_key, 64'h1111_2222_3333_4444);
    chk("dual_abort_pulses", 64'(n_abort), 64'd1);

    // Top of key space: one chunk, then the base wraps.
    setup(3, 3, -1, 0, 0);
    run_search(56'hFF_FFFF_FFFF_FFF8, 56'hFF_FFFF_FFFF_FFFF, 0, 0);
    chk("wrap_chunks", 64'(chunks), 64'd1);
    chk("wrap_key", keys_seen[0], 64'hFEFE_FEFE_FEFE_FEF0);

    // go while draining is ignored.
    setup(5, 5, -1, 0, 0);
    run_search(56'd0, 56'd63, 1, 0);
    chk("draingo_chunks", 64'(chunks), 64'd4);
    for (int k = 0; k < 4; k++) chk("draingo_key", keys_seen[k], exp_keys[k]);

    // Reset mid-dispatch with a reservation outstanding, then restart.
    setup(3, 3, -1, 0, 0);
    key_first = 56'd0; key_last = 56'hFFFF;
    step(1); step();
    for (int c = 0; c < 50 && m_run == '0; c++) step();
    step(0, 0, 1);
    step();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_chunks", 64'(chunks), 64'd0);
    chk("midrst_run", 64'(core_run), 64'd0);
    chk("midrst_key", core_key, 64'd0);
    step(1); step();
    for (int c = 0; c < 50 && m_cnt == 0; c++) step();
    chk("restart_chunks", 64'(chunks), 64'd1);
    step(0, 1);
    for (int c = 0; c < 100 && m_ph != M_DONE; c++) step();
    chk("stop_done", 64'(done), 64'd1);
    chk("stop_found", 64'(found), 64'd0);

    // Random searches with random latencies, hits, stops, stray go/found pulses.
    for (int it = 0; it < 12; it++) begin
      logic [55:0] f;
      hit_val[0] = {$urandom, $urandom};
      hit_val[1] = {$urandom, $urandom};
      setup(1, 5, $urandom_range(0, 6), $urandom_range(0, 3) == 0, 1);
      f = 56'($urandom_range(0, 200));
      run_search(f, f + 56'($urandom_range(0, 200)), $urandom_range(0, 1), 1);
    end

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
